// File: rtl/alarm_qualifier_nch.sv
// Multi-channel debounced alarm latch on the term a | (d & ~x).
// Per-channel qualify/latch/ack FSM plus a saturating event counter.
module alarm_qualifier_nch #(
    parameter int CH    = 4,
    parameter int DEB   = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CH-1:0]    d,
    input  logic [CH-1:0]    x,
    input  logic [CH-1:0]    a,
    input  logic [CH-1:0]    ack,
    output logic [CH-1:0]    l_raw,
    output logic [CH-1:0]    l_out,
    output logic             any_alarm,
    output logic [CNT_W-1:0] event_cnt
);

    localparam int QW = $clog2(DEB + 1);
    localparam int SW = $clog2(CH + 1);
    localparam int TW = ((CNT_W > SW) ? CNT_W : SW) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_QUAL  = 2'd1;
    localparam logic [1:0] S_ALARM = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    localparam logic [QW-1:0] DEB_Q = QW'(DEB);
    localparam logic [TW-1:0] MAX_V =
        {{(TW - CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [1:0]       state_q [CH];
    logic [1:0]       state_d [CH];
    logic [QW-1:0]    qcnt_q  [CH];
    logic [QW-1:0]    qcnt_d  [CH];
    logic [CH-1:0]    enter;
    logic [CH-1:0]    l_out_d;
    logic [CH-1:0]    l_out_q;
    logic             any_q;
    logic [SW-1:0]    n_enter;
    logic [TW-1:0]    sum_w;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic [QW-1:0]    qnxt;

    // Raw alarm term, no reset dependence.
    always_comb begin
        l_raw = a | (d & ~x);
    end

    // Per-channel next state: debounce, latch, acknowledge, wait for low.
    always_comb begin
        enter   = '0;
        l_out_d = '0;
        qnxt    = '0;
        for (int i = 0; i < CH; i++) begin
            state_d[i] = state_q[i];
            qcnt_d[i]  = qcnt_q[i];
            qnxt       = qcnt_q[i] + QW'(1);
            case (state_q[i])
                S_IDLE: begin
                    if (l_raw[i]) begin
                        if (DEB == 1) begin
                            state_d[i] = S_ALARM;
                            qcnt_d[i]  = '0;
                            enter[i]   = 1'b1;
                        end else begin
                            state_d[i] = S_QUAL;
                            qcnt_d[i]  = QW'(1);
                        end
                    end
                end
                S_QUAL: begin
                    if (!l_raw[i]) begin
                        state_d[i] = S_IDLE;
                        qcnt_d[i]  = '0;
                    end else if (qnxt == DEB_Q) begin
                        state_d[i] = S_ALARM;
                        qcnt_d[i]  = '0;
                        enter[i]   = 1'b1;
                    end else begin
                        qcnt_d[i]  = qnxt;
                    end
                end
                S_ALARM: begin
                    if (ack[i]) begin
                        state_d[i] = l_raw[i] ? S_WAIT : S_IDLE;
                        qcnt_d[i]  = '0;
                    end
                end
                default: begin
                    if (!l_raw[i]) begin
                        state_d[i] = S_IDLE;
                    end
                end
            endcase
            l_out_d[i] = (state_d[i] == S_ALARM);
        end
    end

    // Count this edge's ALARM entries and saturate the running total.
    always_comb begin
        n_enter = '0;
        for (int i = 0; i < CH; i++) begin
            n_enter = n_enter + SW'(enter[i]);
        end
        sum_w = TW'(cnt_q) + TW'(n_enter);
        cnt_d = (sum_w > MAX_V) ? {CNT_W{1'b1}} : sum_w[CNT_W-1:0];
    end

    // State, latched alarms and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= S_IDLE;
                qcnt_q[i]  <= '0;
            end
            l_out_q <= '0;
            any_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= state_d[i];
                qcnt_q[i]  <= qcnt_d[i];
            end
            l_out_q <= l_out_d;
            any_q   <= |l_out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign l_out     = l_out_q;
    assign any_alarm = any_q;
    assign event_cnt = cnt_q;

endmodule

// File: tb/tb_alarm_qualifier_nch.sv
// Bench for alarm_qualifier_nch: directed scenarios plus random traffic
// checked every cycle against a behavioural model.
module tb_alarm_qualifier_nch;

    localparam int CH    = 4;
    localparam int DEB   = 3;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CH-1:0]    d, x, a, ack;
    logic [CH-1:0]    l_raw, l_out;
    logic             any_alarm;
    logic [CNT_W-1:0] event_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: streak length, latched flag, blocked-until-low flag, count.
    int run [CH];
    bit lat [CH];
    bit blk [CH];
    int mcnt;

    alarm_qualifier_nch #(.CH(CH), .DEB(DEB), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .d(d), .x(x), .a(a), .ack(ack),
        .l_raw(l_raw), .l_out(l_out), .any_alarm(any_alarm),
        .event_cnt(event_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model advanced on each rising edge.
    always @(posedge clk) begin
        int n;
        bit raw;
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                run[i] = 0; lat[i] = 0; blk[i] = 0;
            end
            mcnt = 0;
        end else begin
            n = 0;
            for (int i = 0; i < CH; i++) begin
                raw = a[i] | (d[i] & ~x[i]);
                if (lat[i]) begin
                    if (ack[i]) begin
                        lat[i] = 0;
                        blk[i] = raw;
                    end
                end else if (blk[i]) begin
                    if (!raw) blk[i] = 0;
                end else if (raw) begin
                    run[i]++;
                    if (run[i] == DEB) begin
                        lat[i] = 1; run[i] = 0; n++;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            mcnt = (mcnt + n > CMAX) ? CMAX : mcnt + n;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic [CH-1:0] el, er;
        if (chk_en) begin
            for (int i = 0; i < CH; i++) begin
                el[i] = lat[i];
                er[i] = a[i] | (d[i] & ~x[i]);
            end
            chk("l_raw", 32'(l_raw), 32'(er));
            chk("l_out", 32'(l_out), 32'(el));
            chk("any_alarm", 32'(any_alarm), 32'(|el));
            chk("event_cnt", 32'(event_cnt), 32'(mcnt));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drv(input logic [CH-1:0] dd, input logic [CH-1:0] xx,
                       input logic [CH-1:0] aa, input logic [CH-1:0] kk);
        d = dd; x = xx; a = aa; ack = kk;
    endtask

    initial begin
        logic [2:0] c;
        logic [7:0] rtab;
        rtab = 8'b1011_1010;
        rst_n = 1'b0;
        drv('0, '0, '0, '0);
        step(2);
        chk_en = 1'b1;
        chk("rst_lout", 32'(l_out), 0);
        chk("rst_cnt", 32'(event_cnt), 0);
        chk("rst_any", 32'(any_alarm), 0);
        rst_n = 1'b1;
        step();

        // Combinational term on ch0, each combo held one cycle.
        for (int k = 0; k < 8; k++) begin
            c = 3'(k);
            drv({3'b0, c[2]}, {3'b0, c[1]}, {3'b0, c[0]}, '0);
            #1;
            chk("raw_tab", 32'(l_raw[0]), 32'(rtab[k]));
            step();
            drv('0, '0, '0, '0);
            step();
        end
        chk("comb_lout", 32'(l_out), 0);

        // Debounce on ch1: two highs do not qualify, three do.
        drv(4'b0010, '0, '0, '0);
        step(2);
        drv('0, '0, '0, '0);
        step();
        chk("deb2_lout", 32'(l_out[1]), 0);
        chk("deb2_cnt", 32'(event_cnt), 0);
        drv(4'b0010, '0, '0, '0);
        step(2);
        chk("deb_pre", 32'(l_out[1]), 0);
        step();
        chk("deb3_lout", 32'(l_out[1]), 1);
        chk("deb3_cnt", 32'(event_cnt), 1);
        chk("deb3_any", 32'(any_alarm), 1);

        // Ack with raw still high: no re-latch until raw drops.
        drv(4'b0010, '0, '0, 4'b0010);
        step();
        chk("ack_lout", 32'(l_out[1]), 0);
        drv(4'b0010, '0, '0, '0);
        step(10);
        chk("wait_lout", 32'(l_out[1]), 0);
        chk("wait_cnt", 32'(event_cnt), 1);
        drv('0, '0, '0, '0);
        step();
        drv(4'b0010, '0, '0, '0);
        step(3);
        chk("relatch", 32'(l_out[1]), 1);
        chk("relatch_cnt", 32'(event_cnt), 2);
        drv('0, '0, '0, 4'b0010);
        step(2);

        // Simultaneous entry on all channels (mix of a and d terms).
        drv(4'b1100, 4'b0000, 4'b0011, '0);
        step(2);
        chk("sim_pre", 32'(l_out), 0);
        step();
        chk("sim_lout", 32'(l_out), 32'hF);
        chk("sim_cnt", 32'(event_cnt), 6);
        drv('0, '0, '0, 4'hF);
        step();

        // Saturation: three more events take the count past 7.
        for (int k = 0; k < 3; k++) begin
            drv('0, '0, 4'b0001, '0);
            step(3);
            drv('0, '0, '0, 4'b0001);
            step();
            drv('0, '0, '0, '0);
            step();
        end
        chk("sat_cnt", 32'(event_cnt), 7);

        // Reset with ch1 in ALARM and ch0 in QUAL.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drv(4'b0010, '0, '0, '0);
        step(3);
        drv(4'b0011, '0, '0, '0);
        step(2);
        rst_n = 1'b0;
        step();
        chk("mrst_lout", 32'(l_out), 0);
        chk("mrst_any", 32'(any_alarm), 0);
        chk("mrst_cnt", 32'(event_cnt), 0);
        rst_n = 1'b1;
        step(2);
        chk("mrst_req", 32'(l_out), 0);
        step();
        chk("mrst_full", 32'(l_out), 32'h3);
        chk("mrst_cnt2", 32'(event_cnt), 2);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < CH; i++) begin
                d[i]   = ($urandom_range(9) < 8);
                x[i]   = ($urandom_range(9) == 0);
                a[i]   = ($urandom_range(19) == 0);
                ack[i] = ($urandom_range(5) == 0);
            end
            rst_n = ($urandom_range(299) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
